// File: rtl/toggle_rx_pkg.sv
// Shared types and defaults for the toggle-event receiver.
package toggle_rx_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rx_state_t;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned CNT_W_DEF       = 4;

endpackage

// File: rtl/toggle_sync.sv
// Plain flop-chain synchroniser for a single async level; all stages reset to 0.
// Latency SYNC_STAGES cycles; no backpressure.
module toggle_sync
    import toggle_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Nothing may sit between stages, so the chain is a pure shift.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_pulse_rx.sv
// Toggle-link receiver: one registered pulse per toggle, events queued in a saturating pending counter.
// Latency tog_in edge -> evt_pulse SYNC_STAGES+1 cycles; pending drained by evt_valid/evt_ready, ovf sticky on saturation.
// Optional macro TOGGLE_RX_ACK_EN adds the ack_tog T-FF that flips on every accepted event.
module toggle_pulse_rx
    import toggle_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tog_in,
    output logic             evt_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_pending,
`ifdef TOGGLE_RX_ACK_EN
    output logic             ovf,
    output logic             ack_tog
`else
    output logic             ovf
`endif
);

    localparam int unsigned INIT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  PEND_MAX  = '1;

    rx_state_t          r_state;
    rx_state_t          w_state_nxt;
    logic [INIT_W-1:0]  r_init_cnt;
    logic [INIT_W-1:0]  w_init_cnt_nxt;
    logic               r_tog_prev;
    logic               r_evt_pulse;
    logic [CNT_W-1:0]   r_pending;
    logic [CNT_W-1:0]   w_pending_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               w_tog_s;
    logic               w_change;
    logic               w_acc;

    toggle_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .i_async (tog_in),
        .o_sync  (w_tog_s)
    );

    assign w_acc = (r_pending != '0) & evt_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_change       = 1'b0;
        w_pending_nxt  = r_pending;
        w_ovf_nxt      = r_ovf;

        // INIT lets the synchroniser settle so a high line at reset is not an event.
        case (r_state)
            INIT: begin
                if (r_init_cnt == INIT_LAST) begin
                    w_state_nxt = RUN;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            RUN: begin
                w_change = w_tog_s ^ r_tog_prev;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase

        if (w_change && !w_acc) begin
            if (r_pending == PEND_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_pending_nxt = r_pending + 1'b1;
            end
        end else if (!w_change && w_acc) begin
            w_pending_nxt = r_pending - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_tog_prev  <= 1'b0;
            r_evt_pulse <= 1'b0;
            r_pending   <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_cnt_nxt;
            r_tog_prev  <= w_tog_s;
            r_evt_pulse <= w_change;
            r_pending   <= w_pending_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    assign evt_pulse   = r_evt_pulse;
    assign evt_valid   = (r_pending != '0);
    assign evt_pending = r_pending;
    assign ovf         = r_ovf;

`ifdef TOGGLE_RX_ACK_EN
    logic r_ack_tog;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ack_tog <= 1'b0;
        end else if (w_acc) begin
            r_ack_tog <= ~r_ack_tog;
        end
    end

    assign ack_tog = r_ack_tog;
`endif

endmodule

// File: tb/tb_toggle_pulse_rx.sv
// Bench for toggle_pulse_rx: two instances (CNT_W=2 and CNT_W=4) share stimulus; scripted tables,
// saturation/reset sequences and a random phase, all against a sampled-history event model.
module tb_toggle_pulse_rx;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tog_in;
    logic       evt_ready;
    logic       pulse_a, valid_a, ovf_a;
    logic [1:0] pend_a;
    logic       pulse_b, valid_b, ovf_b;
    logic [3:0] pend_b;
`ifdef TOGGLE_RX_ACK_EN
    logic       ack_a, ack_b;
`endif

    always #5 clk = ~clk;

    toggle_pulse_rx #(.SYNC_STAGES(S), .CNT_W(2)) u_a (
        .clk         (clk),
        .rstn        (rstn),
        .tog_in      (tog_in),
        .evt_pulse   (pulse_a),
        .evt_valid   (valid_a),
        .evt_ready   (evt_ready),
        .evt_pending (pend_a),
`ifdef TOGGLE_RX_ACK_EN
        .ovf         (ovf_a),
        .ack_tog     (ack_a)
`else
        .ovf         (ovf_a)
`endif
    );

    toggle_pulse_rx #(.SYNC_STAGES(S), .CNT_W(4)) u_b (
        .clk         (clk),
        .rstn        (rstn),
        .tog_in      (tog_in),
        .evt_pulse   (pulse_b),
        .evt_valid   (valid_b),
        .evt_ready   (evt_ready),
        .evt_pending (pend_b),
`ifdef TOGGLE_RX_ACK_EN
        .ovf         (ovf_b),
        .ack_tog     (ack_b)
`else
        .ovf         (ovf_b)
`endif
    );

    int   n_pass = 0;
    int   n_tot  = 0;
    int   edge_n = 0;
    int   rel    = 0;
    logic tin_h[$];
    bit   m_pulse;
    int   m_pend[2];
    bit   m_ovf[2];
    bit   m_ack[2];
    int   maxv[2] = '{3, 15};

    typedef struct {
        logic tog;
        logic rdy;
        logic pulse;
        int   pend;
        logic ack;
    } vec_t;
    vec_t tbl[27];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic check_model();
        chk("A.pulse", pulse_a, m_pulse);
        chk("A.pend",  pend_a,  m_pend[0]);
        chk("A.valid", valid_a, m_pend[0] != 0);
        chk("A.ovf",   ovf_a,   m_ovf[0]);
        chk("B.pulse", pulse_b, m_pulse);
        chk("B.pend",  pend_b,  m_pend[1]);
        chk("B.valid", valid_b, m_pend[1] != 0);
        chk("B.ovf",   ovf_b,   m_ovf[1]);
`ifdef TOGGLE_RX_ACK_EN
        chk("A.ack",   ack_a,   m_ack[0]);
        chk("B.ack",   ack_b,   m_ack[1]);
`endif
    endtask

    // Model: an event is seen when the line level sampled SYNC_STAGES edges ago differs from the
    // one before it, provided the receiver has been out of reset long enough to have settled.
    task automatic tick();
        bit acc;
        tin_h.push_back(tog_in);
        if (!rstn) begin
            rel     = edge_n;
            m_pulse = 0;
            for (int d = 0; d < 2; d++) begin
                m_pend[d] = 0;
                m_ovf[d]  = 0;
                m_ack[d]  = 0;
            end
        end else begin
            m_pulse = (edge_n - rel >= S + 2) && (tin_h[edge_n-S] != tin_h[edge_n-S-1]);
            for (int d = 0; d < 2; d++) begin
                acc = (m_pend[d] != 0) && evt_ready;
                if (acc) m_ack[d] = !m_ack[d];
                if (m_pulse && !acc) begin
                    if (m_pend[d] == maxv[d]) m_ovf[d] = 1;
                    else m_pend[d]++;
                end else if (!m_pulse && acc) begin
                    m_pend[d]--;
                end
            end
        end
        edge_n++;
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 1, 0};
        tbl[3]  = '{0, 0, 0, 1, 0};
        tbl[4]  = '{1, 0, 0, 1, 0};
        tbl[5]  = '{1, 0, 0, 1, 0};
        tbl[6]  = '{1, 0, 1, 2, 0};
        tbl[7]  = '{1, 0, 0, 2, 0};
        tbl[8]  = '{0, 0, 0, 2, 0};
        tbl[9]  = '{0, 0, 0, 2, 0};
        tbl[10] = '{0, 0, 1, 3, 0};
        tbl[11] = '{0, 1, 0, 2, 1};
        tbl[12] = '{0, 1, 0, 1, 0};
        tbl[13] = '{0, 1, 0, 0, 1};
        tbl[14] = '{0, 1, 0, 0, 1};
        tbl[15] = '{1, 0, 0, 0, 1};
        tbl[16] = '{1, 0, 0, 0, 1};
        tbl[17] = '{1, 0, 1, 1, 1};
        tbl[18] = '{1, 0, 0, 1, 1};
        tbl[19] = '{0, 0, 0, 1, 1};
        tbl[20] = '{0, 0, 0, 1, 1};
        tbl[21] = '{0, 0, 1, 2, 1};
        tbl[22] = '{0, 0, 0, 2, 1};
        tbl[23] = '{1, 0, 0, 2, 1};
        tbl[24] = '{1, 0, 0, 2, 1};
        tbl[25] = '{1, 1, 1, 2, 0};
        tbl[26] = '{1, 0, 0, 2, 0};

        // Line held high through reset must not produce an event.
        rstn      = 1'b0;
        tog_in    = 1'b1;
        evt_ready = 1'b0;
        repeat (3) tick();
        chk("rst.pulse", pulse_a, 0);
        chk("rst.pend",  pend_a,  0);
        chk("rst.valid", valid_a, 0);
        chk("rst.ovf",   ovf_a,   0);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1.pulseA", pulse_a, 0);
            chk("t1.pulseB", pulse_b, 0);
            chk("t1.pend",   pend_a,  0);
        end

        // Latency, queueing, draining and simultaneous toggle+accept.
        for (int i = 0; i < 27; i++) begin
            tog_in    = tbl[i].tog;
            evt_ready = tbl[i].rdy;
            tick();
            chk("tbl.pulse", pulse_a, tbl[i].pulse);
            chk("tbl.pendA", pend_a,  tbl[i].pend);
            chk("tbl.pendB", pend_b,  tbl[i].pend);
            chk("tbl.valid", valid_a, tbl[i].pend != 0);
`ifdef TOGGLE_RX_ACK_EN
            chk("tbl.ack",   ack_a,   tbl[i].ack);
`endif
        end

        // Saturation of the narrow counter.
        evt_ready = 1'b0;
        tog_in    = 1'b0;
        rstn      = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (6) tick();
        for (int k = 1; k <= 5; k++) begin
            tog_in = ~tog_in;
            repeat (3) tick();
            chk("sat.pulse", pulse_a, 1);
            tick();
            chk("sat.pulse0", pulse_a, 0);
            chk("sat.pendA",  pend_a,  (k > 3) ? 3 : k);
            chk("sat.ovfA",   ovf_a,   k >= 4);
            chk("sat.pendB",  pend_b,  k);
            chk("sat.ovfB",   ovf_b,   0);
        end
        evt_ready = 1'b1;
        for (int k = 2; k >= 0; k--) begin
            tick();
            chk("drain.pendA", pend_a, k);
        end
        evt_ready = 1'b0;
        chk("drain.ovfA",  ovf_a,   1);
        chk("drain.valid", valid_a, 0);
        chk("drain.pendB", pend_b,  2);

        // Refill, then reset mid-operation with the line high.
        for (int k = 0; k < 3; k++) begin
            tog_in = ~tog_in;
            repeat (4) tick();
        end
        chk("refill.pendA", pend_a, 3);
        chk("refill.ovfA",  ovf_a,  1);
        rstn   = 1'b0;
        tog_in = 1'b1;
        tick();
        chk("mrst.pendA", pend_a, 0);
        chk("mrst.ovfA",  ovf_a,  0);
        chk("mrst.valid", valid_a, 0);
        chk("mrst.pendB", pend_b, 0);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mrst.nopulse", pulse_a, 0);
        end

        // Random traffic including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) tog_in = ~tog_in;
            evt_ready = ($urandom_range(0, 2) == 0);
            rstn      = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
